branch_predictor: RTL and testbench

Parametrised front-end branch predictor: a successor to the fixed two-slot, always-not-taken predictor. It sits between the instruction fetch stage and the instruction buffer. Each cycle it decodes FETCH_WIDTH fetched instructions, looks up a 2-bit-counter branch history table (BHT) and a direct-mapped branch target buffer (BTB), and drives the redirect address to the PC unit and per-slot enables to the instruction buffer. Tables are trained from the back-end resolution port.

---
 rtl/branch_predictor.sv | 146 ++++++++++++++
 tb/tb_branch_predictor.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Front-end branch predictor: per-slot branch decode, 2-bit counter BHT and
// direct-mapped BTB lookup, with tables trained from the resolution port.
module branch_predictor #(
    parameter int FETCH_WIDTH = 2,
    parameter int BHT_IDX_W   = 8,
    parameter int BTB_IDX_W   = 6,
    parameter int BTB_TAG_W   = 10,
    localparam int SLOT_W     = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               pc_i,
    input  logic [FETCH_WIDTH*32-1:0] inst_i,
    input  logic [FETCH_WIDTH-1:0]    inst_en_i,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic                      upd_en_i,
    input  logic [31:0]               upd_pc_i,
    input  logic                      upd_taken_i,
    input  logic [31:0]               upd_target_i,
    output logic [FETCH_WIDTH-1:0]    is_branch_o,
    output logic                      pred_taken_o,
    output logic [SLOT_W-1:0]         pred_slot_o,
    output logic [31:0]               pred_addr_o,
    output logic [FETCH_WIDTH-1:0]    fetch_en_o,
    output logic                      is_valid_o
);

    localparam int BHT_N  = 1 << BHT_IDX_W;
    localparam int BTB_N  = 1 << BTB_IDX_W;
    localparam int TAG_LO = BTB_IDX_W + 2;
    localparam int TAG_HI = BTB_IDX_W + BTB_TAG_W + 1;

    logic [1:0]           bht_reg        [BHT_N];
    logic                 btb_valid_reg  [BTB_N];
    logic [BTB_TAG_W-1:0] btb_tag_reg    [BTB_N];
    logic [31:0]          btb_target_reg [BTB_N];

    // ---------------- training ----------------
    logic [BHT_IDX_W-1:0] upd_bht_idx;
    logic [BTB_IDX_W-1:0] upd_btb_idx;
    logic [BTB_TAG_W-1:0] upd_tag;
    logic [1:0]           upd_ctr;
    logic [1:0]           ctr_next;

    assign upd_bht_idx = upd_pc_i[BHT_IDX_W+1:2];
    assign upd_btb_idx = upd_pc_i[BTB_IDX_W+1:2];
    assign upd_tag     = upd_pc_i[TAG_HI:TAG_LO];
    assign upd_ctr     = bht_reg[upd_bht_idx];

    always_comb begin
        ctr_next = upd_ctr;
        if (upd_taken_i) begin
            if (upd_ctr != 2'b11) ctr_next = upd_ctr + 2'd1;
        end else if (upd_ctr != 2'b00) begin
            ctr_next = upd_ctr - 2'd1;
        end
    end

    // Only taken resolutions allocate into the BTB; aliases are simply overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_N; i++) bht_reg[i] <= 2'b01;
            for (int i = 0; i < BTB_N; i++) begin
                btb_valid_reg[i]  <= 1'b0;
                btb_tag_reg[i]    <= '0;
                btb_target_reg[i] <= '0;
            end
        end else if (upd_en_i) begin
            bht_reg[upd_bht_idx] <= ctr_next;
            if (upd_taken_i) begin
                btb_valid_reg[upd_btb_idx]  <= 1'b1;
                btb_tag_reg[upd_btb_idx]    <= upd_tag;
                btb_target_reg[upd_btb_idx] <= upd_target_i;
            end
        end
    end

    // ---------------- per-slot lookup ----------------
    logic [FETCH_WIDTH-1:0] slot_taken;
    logic [31:0]            slot_target [FETCH_WIDTH];

    genvar gi;
    generate
        for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_slot
            logic [31:0]          slot_pc;
            logic [5:0]           opcode;
            logic                 uncond;
            logic                 btb_hit;
            logic [BHT_IDX_W-1:0] bht_idx;
            logic [BTB_IDX_W-1:0] btb_idx;
            logic [BTB_TAG_W-1:0] tag;
            logic                 unused_slot_pc;

            assign slot_pc = pc_i + 32'(4 * gi);
            assign opcode  = inst_i[gi*32+26 +: 6];
            assign bht_idx = slot_pc[BHT_IDX_W+1:2];
            assign btb_idx = slot_pc[BTB_IDX_W+1:2];
            assign tag     = slot_pc[TAG_HI:TAG_LO];
            assign uncond  = (opcode == 6'b010100) || (opcode == 6'b010101);
            assign btb_hit = btb_valid_reg[btb_idx] && (btb_tag_reg[btb_idx] == tag);

            assign is_branch_o[gi] = (opcode >= 6'b010010) && (opcode <= 6'b011011);
            assign slot_taken[gi]  = inst_en_i[gi] && is_branch_o[gi] && btb_hit
                                     && (uncond || bht_reg[bht_idx][1]);
            assign slot_target[gi] = btb_target_reg[btb_idx];
            assign unused_slot_pc  = ^slot_pc;
        end
    endgenerate

    // ---------------- slot priority ----------------
    logic                   any_taken;
    logic [SLOT_W-1:0]      win_slot;
    logic [31:0]            win_target;
    logic [FETCH_WIDTH-1:0] keep_mask;

    always_comb begin
        any_taken  = 1'b0;
        win_slot   = '0;
        win_target = '0;
        keep_mask  = '1;
        // Scan downward so the lowest-numbered taken slot is the one left standing.
        for (int s = FETCH_WIDTH - 1; s >= 0; s--) begin
            if (slot_taken[s]) begin
                any_taken  = 1'b1;
                win_slot   = SLOT_W'(s);
                win_target = slot_target[s];
            end
        end
        for (int s = 0; s < FETCH_WIDTH; s++) begin
            keep_mask[s] = !any_taken || (s <= int'(win_slot));
        end
    end

    logic block_fetch;
    logic unused_bits;

    assign block_fetch  = stall_i || flush_i;
    assign pred_taken_o = any_taken && !block_fetch;
    assign pred_slot_o  = win_slot;
    assign pred_addr_o  = any_taken ? win_target : (pc_i + 32'(4 * FETCH_WIDTH));
    assign fetch_en_o   = block_fetch ? '0 : (inst_en_i & keep_mask);
    assign is_valid_o   = !(flush_i || slot_taken[0]);
    assign unused_bits  = ^{inst_i, upd_pc_i};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a table-level behavioural model is checked
// against the DUT every cycle, plus literal expectations from hand calculation.
module tb_branch_predictor;

    localparam int FW = 2;

    logic          clk;
    logic          rst_n;
    logic [31:0]   pc_i;
    logic [FW*32-1:0] inst_i;
    logic [FW-1:0] inst_en_i;
    logic          stall_i;
    logic          flush_i;
    logic          upd_en_i;
    logic [31:0]   upd_pc_i;
    logic          upd_taken_i;
    logic [31:0]   upd_target_i;
    logic [FW-1:0] is_branch_o;
    logic          pred_taken_o;
    logic [0:0]    pred_slot_o;
    logic [31:0]   pred_addr_o;
    logic [FW-1:0] fetch_en_o;
    logic          is_valid_o;

    branch_predictor #(
        .FETCH_WIDTH(FW), .BHT_IDX_W(8), .BTB_IDX_W(6), .BTB_TAG_W(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .inst_i(inst_i), .inst_en_i(inst_en_i),
        .stall_i(stall_i), .flush_i(flush_i), .upd_en_i(upd_en_i), .upd_pc_i(upd_pc_i),
        .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i), .is_branch_o(is_branch_o),
        .pred_taken_o(pred_taken_o), .pred_slot_o(pred_slot_o), .pred_addr_o(pred_addr_o),
        .fetch_en_o(fetch_en_o), .is_valid_o(is_valid_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural table model ----------------
    int          m_ctr   [256];
    bit          m_valid [64];
    int          m_tag   [64];
    logic [31:0] m_tgt   [64];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) m_ctr[i] <= 1;
            for (int i = 0; i < 64; i++) begin
                m_valid[i] <= 1'b0;
                m_tag[i]   <= 0;
                m_tgt[i]   <= 32'h0;
            end
        end else if (upd_en_i) begin
            int bi, ti;
            bi = int'(upd_pc_i[9:2]);
            ti = int'(upd_pc_i[7:2]);
            if (upd_taken_i) begin
                if (m_ctr[bi] < 3) m_ctr[bi] <= m_ctr[bi] + 1;
                m_valid[ti] <= 1'b1;
                m_tag[ti]   <= int'(upd_pc_i[17:8]);
                m_tgt[ti]   <= upd_target_i;
            end else if (m_ctr[bi] > 0) begin
                m_ctr[bi] <= m_ctr[bi] - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [FW-1:0] e_br, e_fen;
            logic [31:0]   e_addr;
            bit            found;
            int            slot;
            found = 0;
            slot  = 0;
            e_addr = pc_i + 32'd8;
            for (int s = 0; s < FW; s++) begin
                logic [31:0] spc;
                logic [5:0]  op;
                int          bi, ti;
                bit          hit, pred;
                spc = pc_i + 32'(4 * s);
                op  = inst_i[s*32+26 +: 6];
                bi  = int'(spc[9:2]);
                ti  = int'(spc[7:2]);
                e_br[s] = (op >= 18) && (op <= 27);
                hit  = m_valid[ti] && (m_tag[ti] == int'(spc[17:8]));
                pred = inst_en_i[s] && e_br[s] && hit && ((op == 20) || (op == 21) || (m_ctr[bi] >= 2));
                if (pred && !found) begin
                    found  = 1;
                    slot   = s;
                    e_addr = m_tgt[ti];
                end
            end
            for (int s = 0; s < FW; s++)
                e_fen[s] = !stall_i && !flush_i && inst_en_i[s] && (!found || s <= slot);

            chk("is_branch", 32'(is_branch_o), 32'(e_br));
            chk("fetch_en", 32'(fetch_en_o), 32'(e_fen));
            chk("pred_taken", 32'(pred_taken_o), 32'(found && !stall_i && !flush_i));
            if (found && !stall_i && !flush_i) chk("pred_slot", 32'(pred_slot_o), 32'(slot));
            if (!stall_i && !flush_i) chk("pred_addr", pred_addr_o, e_addr);
            if (flush_i) chk("is_valid", 32'(is_valid_o), 32'd0);
            else if (!stall_i) chk("is_valid", 32'(is_valid_o), 32'(!(found && slot == 0)));
            $display("cyc pc=%h en=%b stl=%b fl=%b upd=%b | taken=%b slot=%0d addr=%h fen=%b valid=%b",
                     pc_i, inst_en_i, stall_i, flush_i, upd_en_i, pred_taken_o, pred_slot_o,
                     pred_addr_o, fetch_en_o, is_valid_o);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] mk(input logic [5:0] op);
        return {op, 26'h2A55A5A};
    endfunction

    task automatic pkt(input logic [31:0] pc, input logic [5:0] op0, input logic [5:0] op1,
                       input logic [1:0] en);
        pc_i      = pc;
        inst_i    = {mk(op1), mk(op0)};
        inst_en_i = en;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                          input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            upd_en_i     = 1'b1;
            upd_pc_i     = pc;
            upd_taken_i  = taken;
            upd_target_i = tgt;
        end
        tick();
        upd_en_i = 1'b0;
    endtask

    task automatic lit(input logic taken, input logic [31:0] addr, input logic [1:0] fen,
                       input logic valid);
        chk("lit_taken", 32'(pred_taken_o), 32'(taken));
        chk("lit_addr", pred_addr_o, addr);
        chk("lit_fetch_en", 32'(fetch_en_o), 32'(fen));
        chk("lit_valid", 32'(is_valid_o), 32'(valid));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        pkt(32'h1C00_0000, 6'b010110, 6'b010110, 2'b11);
        // An update presented while reset is held must be discarded.
        upd_en_i = 1'b1;
        upd_pc_i = 32'h1C00_0004;
        upd_taken_i = 1'b1;
        upd_target_i = 32'h1C00_0100;
        settle();
        chk("rst_taken", 32'(pred_taken_o), 32'd0);
        chk("rst_fetch_en", 32'(fetch_en_o), 32'd3);
        tick();
        tick();
        rst_n = 1'b1;
        upd_en_i = 1'b0;
        settle();
        lit(1'b0, 32'h1C00_0008, 2'b11, 1'b1);

        // Train slot-1 branch, then look it up from slot 1 and slot 0.
        do_upd(32'h1C00_0004, 1'b1, 32'h1C00_0100, 2);
        pkt(32'h1C00_0000, 6'b010110, 6'b010110, 2'b11);
        settle();
        lit(1'b1, 32'h1C00_0100, 2'b11, 1'b1);
        chk("lit_slot1", 32'(pred_slot_o), 32'd1);
        tick();
        pkt(32'h1C00_0004, 6'b010110, 6'b010110, 2'b11);
        settle();
        lit(1'b1, 32'h1C00_0100, 2'b01, 1'b0);
        chk("lit_slot0", 32'(pred_slot_o), 32'd0);

        // Disabled slot is ignored.
        tick();
        pkt(32'h1C00_0000, 6'b010110, 6'b010110, 2'b01);
        settle();
        lit(1'b0, 32'h1C00_0008, 2'b01, 1'b1);

        // Flush and stall on a trained hit.
        tick();
        pkt(32'h1C00_0004, 6'b010110, 6'b010110, 2'b11);
        flush_i = 1'b1;
        settle();
        chk("lit_flush_taken", 32'(pred_taken_o), 32'd0);
        chk("lit_flush_fen", 32'(fetch_en_o), 32'd0);
        chk("lit_flush_valid", 32'(is_valid_o), 32'd0);
        tick();
        flush_i = 1'b0;
        stall_i = 1'b1;
        settle();
        chk("lit_stall_taken", 32'(pred_taken_o), 32'd0);
        chk("lit_stall_fen", 32'(fetch_en_o), 32'd0);
        tick();
        stall_i = 1'b0;

        // Same BTB index and BHT index, different tag.
        pkt(32'h1C01_0000, 6'b010110, 6'b010110, 2'b11);
        settle();
        lit(1'b0, 32'h1C01_0008, 2'b11, 1'b1);

        // Counter saturation at both ends.
        do_upd(32'h1C00_0040, 1'b1, 32'h1C00_0200, 5);
        do_upd(32'h1C00_0040, 1'b0, 32'h0, 1);
        pkt(32'h1C00_0040, 6'b010110, 6'b000000, 2'b11);
        settle();
        lit(1'b1, 32'h1C00_0200, 2'b01, 1'b0);
        do_upd(32'h1C00_0040, 1'b0, 32'h0, 2);
        settle();
        lit(1'b0, 32'h1C00_0048, 2'b11, 1'b1);
        do_upd(32'h1C00_0040, 1'b0, 32'h0, 1);
        do_upd(32'h1C00_0040, 1'b1, 32'h1C00_0200, 1);
        settle();
        lit(1'b0, 32'h1C00_0048, 2'b11, 1'b1);

        // Unconditional opcode ignores a strongly not-taken counter.
        do_upd(32'h1C00_0080, 1'b1, 32'h1C00_0300, 1);
        do_upd(32'h1C00_0080, 1'b0, 32'h0, 3);
        pkt(32'h1C00_0080, 6'b010100, 6'b010110, 2'b11);
        settle();
        lit(1'b1, 32'h1C00_0300, 2'b01, 1'b0);
        tick();
        pkt(32'h1C00_0080, 6'b010101, 6'b010110, 2'b11);
        settle();
        lit(1'b1, 32'h1C00_0300, 2'b01, 1'b0);
        tick();
        pkt(32'h1C00_0080, 6'b010110, 6'b010110, 2'b11);
        settle();
        lit(1'b0, 32'h1C00_0088, 2'b11, 1'b1);

        // Update and lookup of the same entry in one cycle: old value first.
        tick();
        pkt(32'h1C00_00C0, 6'b010110, 6'b010110, 2'b11);
        upd_en_i = 1'b1;
        upd_pc_i = 32'h1C00_00C0;
        upd_taken_i = 1'b1;
        upd_target_i = 32'h1C00_0400;
        settle();
        lit(1'b0, 32'h1C00_00C8, 2'b11, 1'b1);
        tick();
        upd_en_i = 1'b0;
        settle();
        lit(1'b1, 32'h1C00_0400, 2'b01, 1'b0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
